status_register: RTL and testbench
==================================

Name: status_register

Overview:
- 6502 processor status register (P) and interrupt-request front end.
- Consumes the ALU flag outputs (carry, zero, negative, overflow) and returns the stored carry to the ALU's carry_in.
- Supplies the packed P byte for PHP/BRK/IRQ pushes and accepts a bus byte for PLP/RTI.
- Synchronises NMI/IRQ pins and presents masked pending requests to the control sequencer.

Parameters:
- P_RESET, 8'h34, value of P after reset (bit5=1, B=1, I=1, others 0).
- SYNC_STAGES, 2, flip-flop stages on nmi_n/irq_n (minimum 2).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous active-high reset
- flag_op  in  flag_op_t  flag update command for this cycle
- alu_carry  in  1  ALU carry_out
- alu_zero  in  1  ALU zero_out
- alu_negative  in  1  ALU negative_out
- alu_overflow  in  1  ALU overflow_out
- data_in  in  8  internal data bus (PLP/RTI pull, BIT operand)
- push_brk  in  1  1 = packed byte carries B=1 (PHP/BRK), 0 = B=0 (IRQ/NMI)
- nmi_n  in  1  asynchronous NMI pin, falling-edge triggered
- irq_n  in  1  asynchronous IRQ pin, level, active-low
- int_ack  in  1  one-cycle pulse from sequencer at interrupt vector fetch
- carry_flag  out  1  stored C, wired to ALU carry_in
- status_out  out  8  packed P for stack push; bit5 forced 1, bit4 = push_brk
- flags  out  8  raw stored P, for branch evaluation
- nmi_pending  out  1  latched NMI request
- irq_pending  out  1  IRQ asserted and I clear

Behaviour:
- Reset (async, active-high): P <= P_RESET.
  - Sync chains reset to 1 (pins idle); nmi_pending <= 0.
  - Outputs during reset: carry_flag=0, flags=8'h34, nmi_pending=0, irq_pending=0.
- Bit map: N7 V6 -5 B4 D3 I2 Z1 C0. Stored bit5 always 1; stored bit4 is never written (holds reset value).
- flag_op decode, registered, effective the cycle after the command edge:
  - FLAG_NONE: hold.
  - FLAG_NZ: N,Z <= alu.
  - FLAG_NZC: N,Z,C <= alu.
  - FLAG_NVZC: N,V,Z,C <= alu.
  - FLAG_BIT: N <= data_in[7], V <= data_in[6], Z <= alu_zero.
  - FLAG_PULL: P <= data_in, with bit5 and bit4 ignored.
  - FLAG_SEC/CLC, FLAG_SEI/CLI, FLAG_SED/CLD, FLAG_CLV: set or clear the single bit.
- int_ack: sets I on the same edge.
  - int_ack with FLAG_CLI or FLAG_PULL in the same cycle: I=1 wins; other bits of the pull still load.
- status_out is combinational from stored P and push_brk, no latency.
- NMI path:
  - nmi_n passes through SYNC_STAGES flops, then an edge register.
  - Synchronised 1->0 transition sets nmi_pending.
  - int_ack clears nmi_pending when it is set.
  - New edge detected in the same cycle as int_ack: set wins, pending stays 1.
  - Low level held without a new edge: no retrigger.
- IRQ path:
  - irq_pending = ~irq_sync & ~P.I, combinational from registered state.
  - Not latched: IRQ dropping before service removes the request.
- Latency:
  - Pin to pending: SYNC_STAGES+1 edges for NMI, SYNC_STAGES edges for IRQ.
  - I-flag change affects irq_pending the cycle after the command.
- Unknown flag_op encodings: hold.

Decomposition:
- control_signals package gains:
  - enum flag_op_t (FLAG_NONE, FLAG_NZ, FLAG_NZC, FLAG_NVZC, FLAG_BIT, FLAG_PULL, FLAG_SEC, FLAG_CLC, FLAG_SEI, FLAG_CLI, FLAG_SED, FLAG_CLD, FLAG_CLV).
  - Bit-index localparams P_C=0, P_Z=1, P_I=2, P_D=3, P_B=4, P_U=5, P_V=6, P_N=7.
- One sub-module: sync_edge, a parameterised N-stage synchroniser with falling-edge strobe, instantiated for nmi_n (edge used) and irq_n (level used).

Test Plan:
- Reset, then release -> flags=8'h34, carry_flag=0, status_out with push_brk=0 gives 8'h24, irq_pending=0, nmi_pending=0.
- FLAG_NVZC with alu N=1,V=1,Z=0,C=1 -> next cycle flags=8'hF5, carry_flag=1; then FLAG_NZ with all alu inputs 0 -> flags=8'h75 (V,C kept).
- FLAG_PULL data_in=8'hCB, then FLAG_BIT data_in=8'h40 with alu_zero=1 -> flags=8'hFB after pull, then 8'h7B; status_out with push_brk=1 gives 8'h7B.
- FLAG_CLI, then irq_n low -> irq_pending=1 after 2 edges; FLAG_SEI -> irq_pending=0 the next cycle while irq_n stays low.
- nmi_n falls and stays low -> nmi_pending=1 after 3 edges; int_ack -> nmi_pending=0, I=1, and no retrigger while low; second fall coincident with int_ack at detect -> pending stays 1.
- Reset asserted mid-pending, between clock edges -> nmi_pending=0 and flags=8'h34 immediately, no clock required.

Source files
------------

// File: rtl/status_register_pkg.sv
// Shared types and bit positions for the 6502 processor status register.
package status_register_pkg;

  typedef enum logic [3:0] {
    FLAG_NONE,
    FLAG_NZ,
    FLAG_NZC,
    FLAG_NVZC,
    FLAG_BIT,
    FLAG_PULL,
    FLAG_SEC,
    FLAG_CLC,
    FLAG_SEI,
    FLAG_CLI,
    FLAG_SED,
    FLAG_CLD,
    FLAG_CLV
  } flag_op_t;

  // P bit map: N7 V6 -5 B4 D3 I2 Z1 C0
  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

endpackage

// File: rtl/status_register_sync_edge.sv
// N-stage pin synchroniser with a falling-edge strobe. Chain resets to the
// idle (high) level so releasing reset with a pin held low still yields an edge.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pin through the chain and keep the previous synchronised level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign fall  = prev & ~chain[STAGES-1];

endmodule

// File: rtl/status_register.sv
// 6502 status register (P) with NMI/IRQ synchronisation and request masking.
module status_register
  import status_register_pkg::*;
#(
  parameter logic [7:0] P_RESET     = 8'h34,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  flag_op_t   flag_op,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_negative,
  input  logic       alu_overflow,
  input  logic [7:0] data_in,
  input  logic       push_brk,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       int_ack,
  output logic       carry_flag,
  output logic [7:0] status_out,
  output logic [7:0] flags,
  output logic       nmi_pending,
  output logic       irq_pending
);

  logic [7:0] p;
  logic [7:0] p_next;
  logic       nmi_level;
  logic       nmi_fall;
  logic       irq_level;
  logic       irq_fall;
  logic       unused_sync;

  sync_edge #(.STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (nmi_n),
    .level (nmi_level),
    .fall  (nmi_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (irq_n),
    .level (irq_level),
    .fall  (irq_fall)
  );

  // NMI uses only the edge and IRQ only the level.
  assign unused_sync = nmi_level ^ irq_fall;

  // Decode the flag command; int_ack is applied last so I=1 beats CLI/PULL.
  always_comb begin
    p_next = p;
    case (flag_op)
      FLAG_NZ: begin
        p_next[P_N] = alu_negative;
        p_next[P_Z] = alu_zero;
      end
      FLAG_NZC: begin
        p_next[P_N] = alu_negative;
        p_next[P_Z] = alu_zero;
        p_next[P_C] = alu_carry;
      end
      FLAG_NVZC: begin
        p_next[P_N] = alu_negative;
        p_next[P_V] = alu_overflow;
        p_next[P_Z] = alu_zero;
        p_next[P_C] = alu_carry;
      end
      FLAG_BIT: begin
        p_next[P_N] = data_in[7];
        p_next[P_V] = data_in[6];
        p_next[P_Z] = alu_zero;
      end
      FLAG_PULL: p_next = data_in;
      FLAG_SEC:  p_next[P_C] = 1'b1;
      FLAG_CLC:  p_next[P_C] = 1'b0;
      FLAG_SEI:  p_next[P_I] = 1'b1;
      FLAG_CLI:  p_next[P_I] = 1'b0;
      FLAG_SED:  p_next[P_D] = 1'b1;
      FLAG_CLD:  p_next[P_D] = 1'b0;
      FLAG_CLV:  p_next[P_V] = 1'b0;
      default:   p_next = p;
    endcase
    if (int_ack) p_next[P_I] = 1'b1;
    // Bit5 is hard-wired high and B is never written after reset.
    p_next[P_U] = 1'b1;
    p_next[P_B] = p[P_B];
  end

  // Status register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) p <= {P_RESET[7:6], 1'b1, P_RESET[4:0]};
    else       p <= p_next;
  end

  // Latched NMI request; a fresh edge outranks the acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         nmi_pending <= 1'b0;
    else if (nmi_fall) nmi_pending <= 1'b1;
    else if (int_ack)  nmi_pending <= 1'b0;
  end

  assign carry_flag  = p[P_C];
  assign flags       = p;
  assign status_out  = {p[7:6], 1'b1, push_brk, p[3:0]};
  assign irq_pending = ~irq_level & ~p[P_I];

endmodule

// File: tb/tb_status_register.sv
// Directed bench for status_register: flag-op vector table plus interrupt and
// reset sequences.
module tb_status_register;
  import status_register_pkg::*;

  logic       clk;
  logic       reset;
  flag_op_t   flag_op;
  logic       alu_carry, alu_zero, alu_negative, alu_overflow;
  logic [7:0] data_in;
  logic       push_brk;
  logic       nmi_n, irq_n, int_ack;
  logic       carry_flag;
  logic [7:0] status_out;
  logic [7:0] flags;
  logic       nmi_pending, irq_pending;

  int total = 0;
  int bad   = 0;

  status_register dut (
    .clk          (clk),
    .reset        (reset),
    .flag_op      (flag_op),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow),
    .data_in      (data_in),
    .push_brk     (push_brk),
    .nmi_n        (nmi_n),
    .irq_n        (irq_n),
    .int_ack      (int_ack),
    .carry_flag   (carry_flag),
    .status_out   (status_out),
    .flags        (flags),
    .nmi_pending  (nmi_pending),
    .irq_pending  (irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    flag_op_t   op;
    logic       n, v, z, c;
    logic [7:0] din;
    logic       brk;
    logic       ack;
    logic [7:0] exp_p;
    logic [7:0] exp_s;
  } vec_t;

  vec_t tv [15];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flag_op = FLAG_NONE;
    {alu_negative, alu_overflow, alu_zero, alu_carry} = 4'b0000;
    data_in = 8'h00;
    push_brk = 1'b0;
    int_ack = 1'b0;
  endtask

  initial begin
    // op, n, v, z, c, data_in, push_brk, int_ack, expected P, expected status_out
    tv[0]  = '{FLAG_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h34, 8'h24};
    tv[1]  = '{FLAG_NVZC, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'hF5, 8'hE5};
    tv[2]  = '{FLAG_NZ,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h75, 8'h65};
    tv[3]  = '{FLAG_PULL, 1'b0, 1'b0, 1'b0, 1'b0, 8'hCB, 1'b0, 1'b0, 8'hFB, 8'hEB};
    tv[4]  = '{FLAG_BIT,  1'b0, 1'b0, 1'b1, 1'b0, 8'h40, 1'b1, 1'b0, 8'h7B, 8'h7B};
    tv[5]  = '{FLAG_CLC,  1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h7A, 8'h7A};
    tv[6]  = '{FLAG_SEC,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h7B, 8'h7B};
    tv[7]  = '{FLAG_CLD,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h73, 8'h63};
    tv[8]  = '{FLAG_SED,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h7B, 8'h6B};
    tv[9]  = '{FLAG_CLV,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3B, 8'h2B};
    tv[10] = '{FLAG_SEI,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3F, 8'h2F};
    tv[11] = '{FLAG_CLI,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3B, 8'h2B};
    tv[12] = '{FLAG_PULL, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h34, 8'h24};
    tv[13] = '{FLAG_NZC,  1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 8'hB6, 8'hB6};
    tv[14] = '{FLAG_CLI,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB6, 8'hA6};

    idle_inputs();
    nmi_n = 1'b1;
    irq_n = 1'b1;
    reset = 1'b1;
    #2;
    check("reset_flags", flags, 8'h34);
    check("reset_carry", {7'b0, carry_flag}, 8'h00);
    check("reset_nmi", {7'b0, nmi_pending}, 8'h00);
    check("reset_irq", {7'b0, irq_pending}, 8'h00);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_flags", flags, 8'h34);
    check("post_reset_status", status_out, 8'h24);

    // Flag-op table; each command is visible after the following edge.
    for (int i = 0; i < 15; i++) begin
      flag_op      = tv[i].op;
      alu_negative = tv[i].n;
      alu_overflow = tv[i].v;
      alu_zero     = tv[i].z;
      alu_carry    = tv[i].c;
      data_in      = tv[i].din;
      push_brk     = tv[i].brk;
      int_ack      = tv[i].ack;
      tick();
      check($sformatf("vec%0d_flags", i), flags, tv[i].exp_p);
      check($sformatf("vec%0d_carry", i), {7'b0, carry_flag}, {7'b0, tv[i].exp_p[0]});
      check($sformatf("vec%0d_status", i), status_out, tv[i].exp_s);
    end

    // Unknown encoding holds P.
    idle_inputs();
    flag_op = flag_op_t'(4'd15);
    alu_carry = 1'b1;
    tick();
    check("unknown_op_hold", flags, 8'hB6);

    // IRQ: level through two sync stages, masked by I, not latched.
    idle_inputs();
    flag_op = FLAG_CLI;
    tick();
    idle_inputs();
    check("irq_idle", {7'b0, irq_pending}, 8'h00);
    irq_n = 1'b0;
    tick();
    check("irq_edge1", {7'b0, irq_pending}, 8'h00);
    tick();
    check("irq_edge2", {7'b0, irq_pending}, 8'h01);
    flag_op = FLAG_SEI;
    #1;
    check("irq_sei_same_cycle", {7'b0, irq_pending}, 8'h01);
    tick();
    idle_inputs();
    check("irq_masked", {7'b0, irq_pending}, 8'h00);
    irq_n = 1'b1;
    flag_op = FLAG_CLI;
    tick();
    idle_inputs();
    tick();
    tick();
    check("irq_dropped", {7'b0, irq_pending}, 8'h00);

    // NMI: falling edge after SYNC_STAGES+1 edges, ack clears, no retrigger.
    nmi_n = 1'b0;
    tick();
    check("nmi_edge1", {7'b0, nmi_pending}, 8'h00);
    tick();
    check("nmi_edge2", {7'b0, nmi_pending}, 8'h00);
    tick();
    check("nmi_edge3", {7'b0, nmi_pending}, 8'h01);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("nmi_ack_clear", {7'b0, nmi_pending}, 8'h00);
    check("nmi_ack_sets_i", {7'b0, flags[2]}, 8'h01);
    for (int k = 0; k < 5; k++) tick();
    check("nmi_no_retrigger", {7'b0, nmi_pending}, 8'h00);
    nmi_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("nmi_released", {7'b0, nmi_pending}, 8'h00);
    nmi_n = 1'b0;
    tick();
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("nmi_set_beats_ack", {7'b0, nmi_pending}, 8'h01);

    // Async reset mid-pending, away from any clock edge.
    flag_op = FLAG_SEC;
    tick();
    idle_inputs();
    check("pre_reset_carry", {7'b0, carry_flag}, 8'h01);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_nmi", {7'b0, nmi_pending}, 8'h00);
    check("async_reset_flags", flags, 8'h34);
    check("async_reset_carry", {7'b0, carry_flag}, 8'h00);
    tick();
    reset = 1'b0;
    nmi_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
